add32_selfcheck: RTL and testbench

- Self-checking stimulus master for the 32-bit registered CLA adder; drives the adder's operand side (enable, a, b, cin) and consumes its result side (sum_r, cout_r).
- Issues NUM_VEC vectors, one at a time: four fixed corner vectors first, then LFSR-generated vectors.
- Compares each result against an internal 33-bit golden sum and reports pass/fail, error count and first failing index.
- Sits next to the adder in the datapath and in the bench top, replacing free-running testbench stimulus for silicon/FPGA bring-up.

---
 rtl/add32_selfcheck.sv | 207 ++++++++++++++++++++
 tb/tb_add32_selfcheck.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/add32_selfcheck.sv
// Self-checking stimulus master for a registered 32-bit adder: corner + LFSR vectors vs a 33-bit golden sum.
// Optional macro ADD32_SELFCHECK_STOP_ON_ERR_EN ends the run at the first mismatching vector.
module add32_selfcheck #(
    parameter int          WIDTH     = 32,
    parameter int          NUM_VEC   = 16,
    parameter int          ADDER_LAT = 1,
    parameter logic [31:0] SEED      = 32'hACE1_2345
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             enable,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             cin,
    input  logic [WIDTH-1:0] sum_r,
    input  logic             cout_r,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      vec_cnt,
    output logic [15:0]      err_cnt,
    output logic [15:0]      first_err_idx
);
`ifdef ADD32_SELFCHECK_STOP_ON_ERR_EN
    localparam logic STOP_ON_ERR = 1'b1;
`else
    localparam logic STOP_ON_ERR = 1'b0;
`endif
    localparam logic [15:0]      NUM_VEC_W = 16'(NUM_VEC);
    localparam logic [15:0]      WAIT_INIT = (ADDER_LAT > 1) ? 16'(ADDER_LAT - 2) : 16'd0;
    localparam logic [15:0]      NO_ERR    = 16'hFFFF;
    localparam logic [WIDTH-1:0] POLY      = WIDTH'(32'h8020_0003);
    localparam logic [WIDTH-1:0] SEED_A    = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] SEED_B    = WIDTH'(~SEED);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRIVE, S_WAIT, S_CHECK, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [15:0]      idx_q, idx_d, vec_cnt_q, vec_cnt_d, err_cnt_q, err_cnt_d;
    logic [15:0]      first_err_q, first_err_d, wait_q, wait_d;
    logic [WIDTH-1:0] lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d, a_q, a_d, b_q, b_d;
    logic             cin_q, cin_d, enable_q, enable_d, busy_q, busy_d;
    logic             done_q, done_d, pass_q, pass_d;
    logic [WIDTH:0]   exp_q, exp_d;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             sel_cin, mismatch;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? POLY : '0);
    endfunction

    always_comb begin
        sel_a   = lfsr_a_q;
        sel_b   = lfsr_b_q;
        sel_cin = lfsr_a_q[0] ^ lfsr_b_q[0];
        case (idx_q)
            16'd0: begin sel_a = '1; sel_b = '0; sel_cin = 1'b1; end
            16'd1: begin
                sel_a   = {1'b1, {(WIDTH-1){1'b0}}};
                sel_b   = {1'b1, {(WIDTH-1){1'b0}}};
                sel_cin = 1'b0;
            end
            16'd2: begin sel_a = '0; sel_b = '0; sel_cin = 1'b0; end
            16'd3: begin
                sel_a   = {1'b0, {(WIDTH-1){1'b1}}};
                sel_b   = WIDTH'(1);
                sel_cin = 1'b0;
            end
            default: ;
        endcase
    end

    assign mismatch = ({cout_r, sum_r} != exp_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        vec_cnt_d   = vec_cnt_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        wait_d      = wait_q;
        lfsr_a_d    = lfsr_a_q;
        lfsr_b_d    = lfsr_b_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        exp_d       = exp_q;
        enable_d    = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    idx_d       = 16'd0;
                    vec_cnt_d   = 16'd0;
                    err_cnt_d   = 16'd0;
                    first_err_d = NO_ERR;
                    lfsr_a_d    = SEED_A;
                    lfsr_b_d    = SEED_B;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                end
            end
            S_LOAD: begin
                if (idx_q == NUM_VEC_W) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_q == 16'd0);
                end else begin
                    a_d      = sel_a;
                    b_d      = sel_b;
                    cin_d    = sel_cin;
                    exp_d    = {1'b0, sel_a} + {1'b0, sel_b} + {{WIDTH{1'b0}}, sel_cin};
                    enable_d = 1'b1;
                    state_d  = S_DRIVE;
                    if (idx_q >= 16'd4) begin
                        lfsr_a_d = lfsr_step(lfsr_a_q);
                        lfsr_b_d = lfsr_step(lfsr_b_q);
                    end
                end
            end
            S_DRIVE: begin
                if (ADDER_LAT > 1) begin
                    state_d = S_WAIT;
                    wait_d  = WAIT_INIT;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_WAIT: begin
                if (wait_q == 16'd0) state_d = S_CHECK;
                else                 wait_d  = wait_q - 16'd1;
            end
            S_CHECK: begin
                vec_cnt_d = vec_cnt_q + 16'd1;
                idx_d     = idx_q + 16'd1;
                state_d   = S_LOAD;
                if (mismatch) begin
                    if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                    if (first_err_q == NO_ERR) first_err_d = idx_q;
                    if (STOP_ON_ERR) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 16'd0;
            vec_cnt_q   <= 16'd0;
            err_cnt_q   <= 16'd0;
            first_err_q <= NO_ERR;
            wait_q      <= 16'd0;
            lfsr_a_q    <= SEED_A;
            lfsr_b_q    <= SEED_B;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            exp_q       <= '0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            vec_cnt_q   <= vec_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            wait_q      <= wait_d;
            lfsr_a_q    <= lfsr_a_d;
            lfsr_b_q    <= lfsr_b_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            exp_q       <= exp_d;
            enable_q    <= enable_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign enable        = enable_q;
    assign a             = a_q;
    assign b             = b_q;
    assign cin           = cin_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign vec_cnt       = vec_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_add32_selfcheck.sv
// Bench for add32_selfcheck: four instances (NUM_VEC 4/16/16/0, one with ADDER_LAT=3) each paired with an adder model.
module tb_add32_selfcheck;
    localparam logic [31:0] SEED = 32'hACE1_2345;
`ifdef ADD32_SELFCHECK_STOP_ON_ERR_EN
    localparam int INJ_VECS = 3;
`else
    localparam int INJ_VECS = 16;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [3:0] start_v = 4'b0;
    logic [3:0] enable_v, cin_v, cout_v, busy_v, done_v, pass_v;
    logic [3:0][31:0] a_v, b_v, sum_v;
    logic [3:0][15:0] vec_v, err_v, fidx_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    add32_selfcheck #(.NUM_VEC(4), .ADDER_LAT(1), .SEED(SEED)) u_nv4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .enable(enable_v[0]), .a(a_v[0]), .b(b_v[0]),
        .cin(cin_v[0]), .sum_r(sum_v[0]), .cout_r(cout_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .vec_cnt(vec_v[0]), .err_cnt(err_v[0]), .first_err_idx(fidx_v[0]));
    add32_selfcheck #(.NUM_VEC(16), .ADDER_LAT(1), .SEED(SEED)) u_nv16 (
        .clk(clk), .rst(rst), .start(start_v[1]), .enable(enable_v[1]), .a(a_v[1]), .b(b_v[1]),
        .cin(cin_v[1]), .sum_r(sum_v[1]), .cout_r(cout_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .vec_cnt(vec_v[1]), .err_cnt(err_v[1]), .first_err_idx(fidx_v[1]));
    add32_selfcheck #(.NUM_VEC(16), .ADDER_LAT(3), .SEED(SEED)) u_lat3 (
        .clk(clk), .rst(rst), .start(start_v[2]), .enable(enable_v[2]), .a(a_v[2]), .b(b_v[2]),
        .cin(cin_v[2]), .sum_r(sum_v[2]), .cout_r(cout_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .vec_cnt(vec_v[2]), .err_cnt(err_v[2]), .first_err_idx(fidx_v[2]));
    add32_selfcheck #(.NUM_VEC(0), .ADDER_LAT(1), .SEED(SEED)) u_nv0 (
        .clk(clk), .rst(rst), .start(start_v[3]), .enable(enable_v[3]), .a(a_v[3]), .b(b_v[3]),
        .cin(cin_v[3]), .sum_r(sum_v[3]), .cout_r(cout_v[3]), .busy(busy_v[3]), .done(done_v[3]),
        .pass(pass_v[3]), .vec_cnt(vec_v[3]), .err_cnt(err_v[3]), .first_err_idx(fidx_v[3]));

    // Enable-pulse log per instance: operands and the cycle number of each pulse.
    int          cyc = 0;
    int          obs_tot[4];
    logic [31:0] obs_a[4][128];
    logic [31:0] obs_b[4][128];
    logic        obs_cin[4][128];
    int          obs_cyc[4][128];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (enable_v[i] && obs_tot[i] < 128) begin
                obs_a[i][obs_tot[i]]   <= a_v[i];
                obs_b[i][obs_tot[i]]   <= b_v[i];
                obs_cin[i][obs_tot[i]] <= cin_v[i];
                obs_cyc[i][obs_tot[i]] <= cyc;
                obs_tot[i]             <= obs_tot[i] + 1;
            end
        end
    end

    // Adder models; instance 1 can corrupt sum bit 0 of vector 2 of a run.
    logic inject = 1'b0;
    int   inj_base = 0;
    for (genvar gi = 0; gi < 4; gi++) begin : g_adder
        logic [32:0] s1, s2, s3;
        logic        flip;
        assign flip = (gi == 1) && inject && ((obs_tot[1] - inj_base) == 2);
        always @(posedge clk) begin
            if (enable_v[gi])
                s1 <= ({1'b0, a_v[gi]} + {1'b0, b_v[gi]} + {32'b0, cin_v[gi]}) ^ {32'b0, flip};
            s2 <= s1;
            s3 <= s2;
        end
        if (gi == 2) begin : g_lat3
            assign {cout_v[gi], sum_v[gi]} = s3;
        end else begin : g_lat1
            assign {cout_v[gi], sum_v[gi]} = s1;
        end
    end

    // Reference vector list built straight from the vector rules.
    logic [31:0] m_a[16], m_b[16];
    logic        m_cin[16];

    task automatic build_model();
        logic [31:0] la, lb;
        la = SEED;
        lb = ~SEED;
        for (int k = 0; k < 16; k++) begin
            case (k)
                0: begin m_a[k] = 32'hFFFF_FFFF; m_b[k] = 32'h0;          m_cin[k] = 1'b1; end
                1: begin m_a[k] = 32'h8000_0000; m_b[k] = 32'h8000_0000; m_cin[k] = 1'b0; end
                2: begin m_a[k] = 32'h0;          m_b[k] = 32'h0;          m_cin[k] = 1'b0; end
                3: begin m_a[k] = 32'h7FFF_FFFF; m_b[k] = 32'h1;          m_cin[k] = 1'b0; end
                default: begin
                    m_a[k] = la; m_b[k] = lb; m_cin[k] = la[0] ^ lb[0];
                    la = (la >> 1) ^ (la[0] ? 32'h8020_0003 : 32'h0);
                    lb = (lb >> 1) ^ (lb[0] ? 32'h8020_0003 : 32'h0);
                end
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); @(negedge clk); rst = 1'b1;
    endtask

    task automatic wait_done(input int i, input int max_cyc, output bit ok, output int nbusy);
        ok = 1'b0;
        nbusy = 0;
        for (int t = 0; t < max_cyc; t++) begin
            if (done_v[i]) begin ok = 1'b1; break; end
            if (busy_v[i]) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++; if (enable_v !== 4'b0) begin errors++; $display("FAIL reset_enable: got %b want 0000", enable_v); end
        checks++; if (a_v !== '0 || b_v !== '0 || cin_v !== 4'b0) begin errors++; $display("FAIL reset_operands: got a=%h b=%h cin=%b want zero", a_v, b_v, cin_v); end
        checks++; if (busy_v !== 4'b0 || done_v !== 4'b0 || pass_v !== 4'b0) begin errors++; $display("FAIL reset_flags: got busy=%b done=%b pass=%b want 0", busy_v, done_v, pass_v); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (vec_v[i] !== 16'd0 || err_v[i] !== 16'd0 || fidx_v[i] !== 16'hFFFF) begin
                errors++; $display("FAIL reset_counters[%0d]: got vec=%h err=%h fidx=%h want 0000 0000 ffff", i, vec_v[i], err_v[i], fidx_v[i]);
            end
        end
    endtask

    task automatic test_corner();
        bit ok; int nb, base;
        logic [32:0] cexp[4], got;
        cexp[0] = 33'h1_0000_0000; cexp[1] = 33'h1_0000_0000; cexp[2] = 33'h0_0000_0000; cexp[3] = 33'h0_8000_0000;
        base = obs_tot[0];
        start_v[0] = 1'b1; @(negedge clk); start_v[0] = 1'b0;
        wait_done(0, 200, ok, nb);
        checks++; if (!ok) begin errors++; $display("FAIL corner_timeout: got done=0 want done=1"); end
        checks++; if (nb !== 13) begin errors++; $display("FAIL corner_busy_cycles: got %0d want 13", nb); end
        checks++; if (pass_v[0] !== 1'b1 || vec_v[0] !== 16'd4 || err_v[0] !== 16'd0 || fidx_v[0] !== 16'hFFFF) begin
            errors++; $display("FAIL corner_result: got pass=%b vec=%0d err=%0d fidx=%h want 1 4 0 ffff", pass_v[0], vec_v[0], err_v[0], fidx_v[0]);
        end
        checks++; if (obs_tot[0] - base !== 4) begin errors++; $display("FAIL corner_enables: got %0d want 4", obs_tot[0] - base); end
        for (int k = 0; k < 4; k++) begin
            got = {1'b0, obs_a[0][base+k]} + {1'b0, obs_b[0][base+k]} + {32'b0, obs_cin[0][base+k]};
            checks++; if (got !== cexp[k]) begin errors++; $display("FAIL corner_sum[%0d]: got %h want %h", k, got, cexp[k]); end
            if (k > 0) begin
                checks++; if (obs_cyc[0][base+k] - obs_cyc[0][base+k-1] !== 3) begin
                    errors++; $display("FAIL corner_spacing[%0d]: got %0d want 3", k, obs_cyc[0][base+k] - obs_cyc[0][base+k-1]);
                end
            end
        end
    endtask

    task automatic test_start_held();
        bit ok; int nb, base;
        base = obs_tot[0];
        start_v[0] = 1'b1; @(negedge clk);
        wait_done(0, 200, ok, nb);
        checks++; if (!ok) begin errors++; $display("FAIL held_timeout: got done=0 want done=1"); end
        checks++; if (vec_v[0] !== 16'd4 || obs_tot[0] - base !== 4) begin
            errors++; $display("FAIL held_no_restart: got vec=%0d enables=%0d want 4 4", vec_v[0], obs_tot[0] - base);
        end
        @(negedge clk);
        checks++; if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b1 || vec_v[0] !== 16'd0 || err_v[0] !== 16'd0) begin
            errors++; $display("FAIL held_relaunch: got done=%b busy=%b vec=%0d err=%0d want 0 1 0 0", done_v[0], busy_v[0], vec_v[0], err_v[0]);
        end
        start_v[0] = 1'b0;
        wait_done(0, 200, ok, nb);
        checks++; if (!ok || pass_v[0] !== 1'b1 || obs_tot[0] - base !== 8) begin
            errors++; $display("FAIL held_second_run: got done=%b pass=%b enables=%0d want 1 1 8", ok, pass_v[0], obs_tot[0] - base);
        end
    endtask

    task automatic test_error_inject();
        bit ok; int nb, base;
        base = obs_tot[1];
        inj_base = base;
        inject = 1'b1;
        start_v[1] = 1'b1; @(negedge clk); start_v[1] = 1'b0;
        wait_done(1, 400, ok, nb);
        inject = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL inject_timeout: got done=0 want done=1"); end
        checks++; if (err_v[1] !== 16'd1 || fidx_v[1] !== 16'd2) begin
            errors++; $display("FAIL inject_err: got err=%0d fidx=%0d want 1 2", err_v[1], fidx_v[1]);
        end
        checks++; if (vec_v[1] !== 16'(INJ_VECS) || pass_v[1] !== 1'b0) begin
            errors++; $display("FAIL inject_result: got vec=%0d pass=%b want %0d 0", vec_v[1], pass_v[1], INJ_VECS);
        end
        checks++; if (obs_tot[1] - base !== INJ_VECS) begin errors++; $display("FAIL inject_enables: got %0d want %0d", obs_tot[1] - base, INJ_VECS); end
    endtask

    task automatic test_latency3();
        bit ok; int nb, base;
        base = obs_tot[2];
        start_v[2] = 1'b1; @(negedge clk); start_v[2] = 1'b0;
        wait_done(2, 400, ok, nb);
        checks++; if (!ok || pass_v[2] !== 1'b1 || vec_v[2] !== 16'd16 || err_v[2] !== 16'd0) begin
            errors++; $display("FAIL lat3_result: got done=%b pass=%b vec=%0d err=%0d want 1 1 16 0", ok, pass_v[2], vec_v[2], err_v[2]);
        end
        checks++; if (obs_tot[2] - base !== 16) begin errors++; $display("FAIL lat3_enables: got %0d want 16", obs_tot[2] - base); end
        for (int k = 0; k < 16; k++) begin
            checks++; if ({obs_a[2][base+k], obs_b[2][base+k], obs_cin[2][base+k]} !== {m_a[k], m_b[k], m_cin[k]}) begin
                errors++; $display("FAIL lat3_vec[%0d]: got %h %h %b want %h %h %b", k, obs_a[2][base+k], obs_b[2][base+k], obs_cin[2][base+k], m_a[k], m_b[k], m_cin[k]);
            end
            if (k > 0) begin
                checks++; if (obs_cyc[2][base+k] - obs_cyc[2][base+k-1] !== 5) begin
                    errors++; $display("FAIL lat3_spacing[%0d]: got %0d want 5", k, obs_cyc[2][base+k] - obs_cyc[2][base+k-1]);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        bit ok, seen; int nb, base;
        logic [31:0] want_a4, want_b4;
        base = obs_tot[1];
        start_v[1] = 1'b1; @(negedge clk); start_v[1] = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (obs_tot[1] - base >= 6) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL midrun_reach_vec5: got %0d enables want 6", obs_tot[1] - base); end
        rst = 1'b0; @(negedge clk); rst = 1'b1;
        checks++; if (busy_v[1] !== 1'b0 || done_v[1] !== 1'b0 || pass_v[1] !== 1'b0 || enable_v[1] !== 1'b0) begin
            errors++; $display("FAIL midrun_flags: got busy=%b done=%b pass=%b en=%b want 0", busy_v[1], done_v[1], pass_v[1], enable_v[1]);
        end
        checks++; if (vec_v[1] !== 16'd0 || err_v[1] !== 16'd0 || fidx_v[1] !== 16'hFFFF || a_v[1] !== 32'd0) begin
            errors++; $display("FAIL midrun_counters: got vec=%h err=%h fidx=%h a=%h want 0 0 ffff 0", vec_v[1], err_v[1], fidx_v[1], a_v[1]);
        end
        base = obs_tot[1];
        start_v[1] = 1'b1; @(negedge clk); start_v[1] = 1'b0;
        wait_done(1, 400, ok, nb);
        checks++; if (!ok || pass_v[1] !== 1'b1 || vec_v[1] !== 16'd16) begin
            errors++; $display("FAIL midrun_rerun: got done=%b pass=%b vec=%0d want 1 1 16", ok, pass_v[1], vec_v[1]);
        end
        want_a4 = 32'hACE1_2345;
        want_b4 = 32'h531E_DCBA;
        checks++; if (obs_a[1][base+4] !== want_a4 || obs_b[1][base+4] !== want_b4) begin
            errors++; $display("FAIL midrun_seed: got a=%h b=%h want %h %h", obs_a[1][base+4], obs_b[1][base+4], want_a4, want_b4);
        end
        for (int k = 0; k < 16; k++) begin
            checks++; if ({obs_a[1][base+k], obs_b[1][base+k], obs_cin[1][base+k]} !== {m_a[k], m_b[k], m_cin[k]}) begin
                errors++; $display("FAIL midrun_vec[%0d]: got %h %h %b want %h %h %b", k, obs_a[1][base+k], obs_b[1][base+k], obs_cin[1][base+k], m_a[k], m_b[k], m_cin[k]);
            end
        end
    endtask

    task automatic test_zero_vec();
        start_v[3] = 1'b1; @(negedge clk); start_v[3] = 1'b0;
        checks++; if (done_v[3] !== 1'b0 || busy_v[3] !== 1'b1) begin
            errors++; $display("FAIL zero_first_cycle: got done=%b busy=%b want 0 1", done_v[3], busy_v[3]);
        end
        @(negedge clk);
        checks++; if (done_v[3] !== 1'b1 || pass_v[3] !== 1'b1 || vec_v[3] !== 16'd0 || busy_v[3] !== 1'b0) begin
            errors++; $display("FAIL zero_done: got done=%b pass=%b vec=%0d busy=%b want 1 1 0 0", done_v[3], pass_v[3], vec_v[3], busy_v[3]);
        end
        repeat (3) @(negedge clk);
        checks++; if (obs_tot[3] !== 0 || done_v[3] !== 1'b1) begin
            errors++; $display("FAIL zero_no_enable: got enables=%0d done=%b want 0 1", obs_tot[3], done_v[3]);
        end
    endtask

    initial begin
        build_model();
        do_reset();
        test_reset();
        test_corner();
        test_start_held();
        test_error_inject();
        test_latency3();
        test_reset_midrun();
        test_zero_vec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
